// File: rtl/dft_sequencer.sv
// Sliding-DFT scheduler: routes each accepted sample to one octave, then sweeps that octave's bins in two passes.
// Optional build macro DFT_SEQ_CYCLECOUNT_EN adds the sweepCycles output.
//
// state | meaning
// IDLE  | waiting for a sample, sampleReady high
// WRITE | one-hot write strobe to the selected octave storage
// SWEEP | issuing bin steps (operation 0 then 1) to the datapath
// DONE  | frameDone pulse, bin/operation back to zero

module dft_sequencer #(
    parameter int OCT  = 5,
    parameter int BINS = 24,
    parameter int N    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [N-1:0]     sampleIn,
    input  logic                    sampleValid,
    output logic                    sampleReady,
    output logic signed [N-1:0]     newSample,
    output logic [OCT-1:0]          writeLines,
    output logic [$clog2(OCT)-1:0]  octave,
    output logic [$clog2(BINS)-1:0] bin,
    output logic                    operation,
    output logic                    stepValid,
    input  logic                    stepReady,
    output logic                    frameDone,
`ifdef DFT_SEQ_CYCLECOUNT_EN
    output logic [15:0]             sweepCycles,
`endif
    output logic                    busy
);

    localparam int OW = $clog2(OCT);
    localparam int BW = $clog2(BINS);

    typedef enum logic [1:0] {IDLE, WRITE, SWEEP, DONE} state_t;

    state_t                state_q, state_d;
    logic [OCT-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [OW-1:0]         oct_sel;
    logic signed [N-1:0]   sample_q, sample_d;
    logic [OCT-1:0]        write_lines_q, write_lines_d;
    logic [OW-1:0]         octave_q, octave_d;
    logic [BW-1:0]         bin_q, bin_d;
    logic                  op_q, op_d;
    logic                  frame_done_q, frame_done_d;

    assign cnt_inc = cnt_q + OCT'(1);

    // Lowest set bit of the incremented count; a wrap to zero lands on the top octave.
    always_comb begin
        oct_sel = OW'(OCT - 1);
        for (int i = OCT - 1; i >= 0; i--) begin
            if (cnt_inc[i]) oct_sel = OW'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sample_d      = sample_q;
        write_lines_d = '0;
        octave_d      = octave_q;
        bin_d         = bin_q;
        op_d          = op_q;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sampleValid) begin
                    sample_d      = sampleIn;
                    cnt_d         = cnt_inc;
                    octave_d      = oct_sel;
                    write_lines_d = OCT'(1) << oct_sel;
                    bin_d         = '0;
                    op_d          = 1'b0;
                    state_d       = WRITE;
                end
            end
            WRITE: state_d = SWEEP;
            SWEEP: begin
                if (stepReady) begin
                    if (bin_q == BW'(BINS - 1)) begin
                        bin_d = '0;
                        if (op_q) begin
                            op_d         = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = DONE;
                        end else begin
                            op_d = 1'b1;
                        end
                    end else begin
                        bin_d = bin_q + BW'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sample_q      <= '0;
            write_lines_q <= '0;
            octave_q      <= '0;
            bin_q         <= '0;
            op_q          <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sample_q      <= sample_d;
            write_lines_q <= write_lines_d;
            octave_q      <= octave_d;
            bin_q         <= bin_d;
            op_q          <= op_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign sampleReady = (state_q == IDLE);
    assign stepValid   = (state_q == SWEEP);
    assign busy        = (state_q != IDLE);
    assign newSample   = sample_q;
    assign writeLines  = write_lines_q;
    assign octave      = octave_q;
    assign bin         = bin_q;
    assign operation   = op_q;
    assign frameDone   = frame_done_q;

`ifdef DFT_SEQ_CYCLECOUNT_EN
    logic [15:0] cyc_q, cyc_d, cyc_inc;
    logic [15:0] sweep_cycles_q, sweep_cycles_d;

    // The DONE cycle itself is included in the latched total.
    always_comb begin
        cyc_inc        = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        cyc_d          = cyc_q;
        sweep_cycles_d = sweep_cycles_q;
        if (state_q == IDLE) begin
            if (sampleValid) cyc_d = '0;
        end else begin
            cyc_d = cyc_inc;
            if (state_q == DONE) sweep_cycles_d = cyc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q          <= '0;
            sweep_cycles_q <= '0;
        end else begin
            cyc_q          <= cyc_d;
            sweep_cycles_q <= sweep_cycles_d;
        end
    end

    assign sweepCycles = sweep_cycles_q;
`endif

endmodule

// File: tb/tb_dft_sequencer.sv
// Self-checking bench for dft_sequencer: directed scenarios plus random traffic against a step-index reference model.
// Build with DFT_SEQ_CYCLECOUNT_EN defined to also cover sweepCycles.

module tb_dft_sequencer;

    localparam int OCT  = 5;
    localparam int BINS = 24;
    localparam int N    = 16;
    localparam int STEPS = 2 * BINS;

    logic        clk;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] new_sample;
    logic [4:0]  write_lines;
    logic [2:0]  octave;
    logic [4:0]  bin;
    logic        operation;
    logic        step_valid;
    logic        step_ready;
    logic        frame_done;
    logic        busy;
`ifdef DFT_SEQ_CYCLECOUNT_EN
    logic [15:0] sweep_cycles;
`endif

    dft_sequencer #(.OCT(OCT), .BINS(BINS), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sampleIn   (sample_in),
        .sampleValid(sample_valid),
        .sampleReady(sample_ready),
        .newSample  (new_sample),
        .writeLines (write_lines),
        .octave     (octave),
        .bin        (bin),
        .operation  (operation),
        .stepValid  (step_valid),
        .stepReady  (step_ready),
        .frameDone  (frame_done),
`ifdef DFT_SEQ_CYCLECOUNT_EN
        .sweepCycles(sweep_cycles),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 write, 2 sweep, 3 done; sweep progress is a flat step index.
    int          m_phase, m_k, m_cnt, m_oct, m_cyc, m_sweep, m_accepts;
    logic [15:0] m_sample;
    logic [4:0]  wl_log[$];
    int          wl_cycles, sv_cycles;

    function automatic int octave_of(input int c);
        int n = 0;
        if (c == 0) return OCT - 1;
        while (c % 2 == 0) begin
            c = c / 2;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_k      = 0;
        m_cnt    = 0;
        m_oct    = 0;
        m_cyc    = 0;
        m_sweep  = 0;
        m_sample = '0;
    endtask

    task automatic compare_all();
        check_eq("sample_ready", sample_ready, m_phase == 0);
        check_eq("busy", busy, m_phase != 0);
        check_eq("step_valid", step_valid, m_phase == 2);
        check_eq("write_lines", write_lines, (m_phase == 1) ? (1 << m_oct) : 0);
        check_eq("frame_done", frame_done, m_phase == 3);
        check_eq("bin", bin, (m_phase == 2) ? (m_k % BINS) : 0);
        check_eq("operation", operation, (m_phase == 2) ? (m_k / BINS) : 0);
        check_eq("new_sample", new_sample, m_sample);
        check_eq("octave", octave, m_oct);
`ifdef DFT_SEQ_CYCLECOUNT_EN
        check_eq("sweep_cycles", sweep_cycles, m_sweep);
`endif
        if (write_lines != 0) begin
            wl_log.push_back(write_lines);
            wl_cycles++;
        end
        if (step_valid) sv_cycles++;
    endtask

    task automatic model_advance();
        if (!rst) return;
        case (m_phase)
            0: if (sample_valid) begin
                m_cnt    = (m_cnt + 1) % (1 << OCT);
                m_oct    = octave_of(m_cnt);
                m_sample = sample_in;
                m_cyc    = 0;
                m_phase  = 1;
                m_accepts++;
            end
            1: begin
                m_cyc++;
                m_k     = 0;
                m_phase = 2;
            end
            2: begin
                m_cyc++;
                if (step_ready) begin
                    m_k++;
                    if (m_k == STEPS) m_phase = 3;
                end
            end
            default: begin
                m_cyc++;
                m_sweep = (m_cyc > 65535) ? 65535 : m_cyc;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while (m_phase != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("idle_reached", m_phase, 0);
    endtask

    int n;
    int t;

    initial begin
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        step_ready   = 1'b0;
        m_accepts    = 0;
        wl_cycles    = 0;
        sv_cycles    = 0;
        model_reset();
        #2;

        // Reset and quiet idle
        do_reset();
        repeat (5) tick();

        // Single sample, stepReady high
        wl_cycles    = 0;
        sample_valid = 1'b1;
        sample_in    = 16'h1234;
        step_ready   = 1'b1;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (!frame_done && n < 200) begin
            tick();
            n++;
        end
        check_eq("frame_latency", n + 1, 50);
        check_eq("single_new_sample", new_sample, 16'h1234);
        tick();
        check_eq("ready_after_done", sample_ready, 1);
        check_eq("single_write_cycles", wl_cycles, 1);
`ifdef DFT_SEQ_CYCLECOUNT_EN
        check_eq("cycles_ready_high", sweep_cycles, 50);
`endif

        // Octave routing with back-to-back samples
        do_reset();
        wl_log.delete();
        sample_valid = 1'b1;
        step_ready   = 1'b1;
        m_accepts    = 0;
        n = 0;
        while (m_accepts < 32 && n < 32 * 60) begin
            sample_in = 16'($urandom);
            tick();
            n++;
        end
        sample_valid = 1'b0;
        run_until_idle(200);
        tick();
        check_eq("route_count", wl_log.size(), 32);
        check_eq("route_s1", wl_log[0], 5'b00001);
        check_eq("route_s2", wl_log[1], 5'b00010);
        check_eq("route_s8", wl_log[7], 5'b01000);
        check_eq("route_s16", wl_log[15], 5'b10000);
        check_eq("route_s32", wl_log[31], 5'b10000);

        // Backpressure with a sample raised mid-sweep
        do_reset();
        sample_valid = 1'b1;
        sample_in    = 16'($urandom);
        step_ready   = 1'b0;
        tick();
        sample_valid = 1'b0;
        m_accepts    = 0;
        sv_cycles    = 0;
        t = 1;
        while (m_accepts < 1 && t < 400) begin
            step_ready = (t % 2 == 1);
            if (t == 40) begin
                sample_valid = 1'b1;
                sample_in    = 16'hBEEF;
            end
            tick();
            t++;
        end
        check_eq("bp_sweep_cycles", sv_cycles, 96);
        check_eq("bp_accept_sample", new_sample, 16'hBEEF);
        check_eq("bp_write_after_done", write_lines, 5'b00010);
`ifdef DFT_SEQ_CYCLECOUNT_EN
        check_eq("cycles_toggled", sweep_cycles, 98);
`endif
        sample_valid = 1'b0;
        step_ready   = 1'b1;
        run_until_idle(200);
`ifdef DFT_SEQ_CYCLECOUNT_EN
        check_eq("cycles_relatch", sweep_cycles, 50);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_in    = 16'($urandom);
            step_ready   = $urandom_range(0, 1) == 1;
            tick();
        end
        sample_valid = 1'b0;
        step_ready   = 1'b1;
        run_until_idle(200);

        // Reset in the middle of a sweep
        sample_valid = 1'b1;
        sample_in    = 16'h7A5C;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (!(m_phase == 2 && m_k == 10) && n < 100) begin
            tick();
            n++;
        end
        check_eq("pre_rst_bin", bin, 10);
        check_eq("pre_rst_op", operation, 0);
        do_reset();
        repeat (3) tick();
        sample_valid = 1'b1;
        sample_in    = 16'h0042;
        tick();
        sample_valid = 1'b0;
        check_eq("post_rst_octave", write_lines, 5'b00001);
        run_until_idle(200);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
